// File: rtl/draw_arbiter_if.sv
// rtl/draw_arbiter_if.sv - request and sprite-drawer signal bundle for draw_arbiter
//
// Groups the per-requester request/operand buses with the drawer handshake.
//   req, req_sprite, req_x, req_y : packed per-requester request and operands
//   grant, done                   : one-hot owner and one-cycle completion pulse
//   draw_start, draw_sprite/x/y   : start pulse and latched operands to the drawer
//   draw_done                     : completion pulse from the drawer
// slave  : arbiter side
// master : requesters plus drawer side
interface draw_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_sprite;
  logic [9*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic                 draw_start;
  logic [3:0]           draw_sprite;
  logic [8:0]           draw_x;
  logic [7:0]           draw_y;
  logic                 draw_done;

  modport slave (
    input  req, req_sprite, req_x, req_y, draw_done,
    output grant, done, draw_start, draw_sprite, draw_x, draw_y
  );

  modport master (
    output req, req_sprite, req_x, req_y, draw_done,
    input  grant, done, draw_start, draw_sprite, draw_x, draw_y
  );
endinterface

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - round-robin arbiter sharing one sprite drawer between requesters
//
// One draw in flight at a time; operands are captured atomically from the winner.
//   clock, resetn : system clock, asynchronous active-low reset
//   bus           : request buses, grant/done, drawer start/operands/done
//   clear_err     : synchronous clear of timeout_err
//   busy          : high whenever the FSM is not idle
//   timeout_err   : sticky, set when the drawer fails to finish in time
module draw_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic          clock,
  input  logic          resetn,
  draw_arbiter_if.slave bus,
  input  logic          clear_err,
  output logic          busy,
  output logic          timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic          found;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  // Rotating priority search starting at ptr.
  always_comb begin
    int idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // draw_done on the terminal cycle takes precedence over the timeout.
  assign timeout_hit = (state == S_WAIT) && !bus.draw_done && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (found) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (bus.draw_done || (cnt == CNT_LAST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.draw_start  <= 1'b0;
      bus.draw_sprite <= '0;
      bus.draw_x      <= '0;
      bus.draw_y      <= '0;
      timeout_err     <= 1'b0;
      cnt             <= '0;
      ptr             <= '0;
      owner           <= '0;
    end else begin
      bus.draw_start <= 1'b0;
      bus.done       <= '0;
      // Set is evaluated after clear so a same-edge timeout keeps the flag.
      if (clear_err)   timeout_err <= 1'b0;
      if (timeout_hit) timeout_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (found) begin
            owner           <= win;
            bus.grant       <= NUM_REQ'(1) << win;
            bus.draw_start  <= 1'b1;
            bus.draw_sprite <= bus.req_sprite[4*int'(win) +: 4];
            bus.draw_x      <= bus.req_x[9*int'(win) +: 9];
            bus.draw_y      <= bus.req_y[8*int'(win) +: 8];
          end
        end
        S_START: cnt <= '0;
        S_WAIT: begin
          // Hold the counter on exit so it never wraps past the terminal value.
          if (state_nxt == S_DONE) bus.done <= bus.grant;
          else                     cnt      <= cnt + 1'b1;
        end
        S_DONE: begin
          bus.grant <= '0;
          ptr       <= (owner == IDX_LAST) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// tb/tb_draw_arbiter.sv - self-checking bench for draw_arbiter with transaction-level reference model
module tb_draw_arbiter;
  localparam int N  = 3;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic resetn;
  logic clear_err = 1'b0;
  logic busy;
  logic timeout_err;

  draw_arbiter_if #(.NUM_REQ(N)) bus ();

  draw_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .bus         (bus.slave),
    .clear_err   (clear_err),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, tracked as owner / wait count / finished.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_waits = 0;
  int         m_i     = 0;
  bit         m_start = 0;
  bit         m_fin   = 0;
  bit         m_err   = 0;
  bit         m_to    = 0;
  logic [3:0] m_spr   = '0;
  logic [8:0] m_x     = '0;
  logic [7:0] m_y     = '0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_owner = -1; m_ptr = 0; m_waits = 0; m_start = 0; m_fin = 0;
      m_err = 0; m_spr = '0; m_x = '0; m_y = '0;
    end else begin
      m_to = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          m_i = (m_ptr + k) % N;
          if (m_owner < 0 && bus.req[m_i]) begin
            m_owner = m_i;
            m_start = 1;
            m_spr   = bus.req_sprite[4*m_i +: 4];
            m_x     = bus.req_x[9*m_i +: 9];
            m_y     = bus.req_y[8*m_i +: 8];
          end
        end
      end else if (m_start) begin
        m_start = 0;
        m_waits = 0;
      end else if (m_fin) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_fin   = 0;
      end else begin
        m_waits++;
        if (bus.draw_done) m_fin = 1;
        else if (m_waits == TO) begin
          m_fin = 1;
          m_to  = 1;
        end
      end
      if (clear_err) m_err = 0;
      if (m_to)      m_err = 1;
    end
  end

  logic [2:0] e_grant;
  always @(negedge clock) begin
    e_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
    chk("grant",       bus.grant,       e_grant);
    chk("done",        bus.done,        m_fin ? e_grant : 3'b000);
    chk("draw_start",  bus.draw_start,  m_start);
    chk("draw_sprite", bus.draw_sprite, m_spr);
    chk("draw_x",      bus.draw_x,      m_x);
    chk("draw_y",      bus.draw_y,      m_y);
    chk("busy",        busy,            m_owner >= 0);
    chk("timeout_err", timeout_err,     m_err);
  end

  // Drawer: completes lat cycles after draw_start (0 = never), optional noise pulses.
  int lat_fixed  = 10;
  bit lat_rand   = 0;
  bit noise_en   = 0;
  bit force_done = 0;
  int dd_left    = 0;
  bit dd_hit     = 0;

  always @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      dd_left       = 0;
      bus.draw_done = 1'b0;
    end else begin
      dd_hit = 0;
      if (bus.draw_start) begin
        if (lat_rand) dd_left = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
        else          dd_left = lat_fixed;
      end else if (dd_left > 0) begin
        dd_left--;
        if (dd_left == 0) dd_hit = 1;
      end
      bus.draw_done = dd_hit | force_done | (noise_en && ($urandom_range(0, 15) == 0));
    end
  end

  // Event log for directed literal checks.
  int         st_cyc[$];
  logic [2:0] st_grant[$];
  logic [3:0] st_spr[$];
  logic [8:0] st_x[$];
  logic [7:0] st_y[$];
  int         dn_cyc[$];
  logic [2:0] dn_val[$];
  logic       dn_err[$];

  always @(negedge clock) begin
    if (resetn && bus.draw_start) begin
      st_cyc.push_back(cyc);
      st_grant.push_back(bus.grant);
      st_spr.push_back(bus.draw_sprite);
      st_x.push_back(bus.draw_x);
      st_y.push_back(bus.draw_y);
    end
    if (resetn && bus.done != 3'b000) begin
      dn_cyc.push_back(cyc);
      dn_val.push_back(bus.done);
      dn_err.push_back(timeout_err);
    end
  end

  task automatic clear_logs();
    st_cyc.delete(); st_grant.delete(); st_spr.delete(); st_x.delete(); st_y.delete();
    dn_cyc.delete(); dn_val.delete(); dn_err.delete();
  endtask

  task automatic set_req(input int i, input logic [3:0] s, input logic [8:0] x, input logic [7:0] y);
    bus.req_sprite[4*i +: 4] = s;
    bus.req_x[9*i +: 9]      = x;
    bus.req_y[8*i +: 8]      = y;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int seen;
    int b;
    seen = 0;
    b    = 0;
    while (seen < n && b < budget) begin
      @(negedge clock);
      b++;
      if (bus.done != 3'b000) seen++;
    end
    if (seen < n) chk("wait_done_budget", seen, n);
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"},  bus.grant,       0);
    chk({tag, "_done"},   bus.done,        0);
    chk({tag, "_start"},  bus.draw_start,  0);
    chk({tag, "_sprite"}, bus.draw_sprite, 0);
    chk({tag, "_x"},      bus.draw_x,      0);
    chk({tag, "_y"},      bus.draw_y,      0);
    chk({tag, "_busy"},   busy,            0);
    chk({tag, "_err"},    timeout_err,     0);
  endtask

  logic [2:0] rr_exp[4];
  logic [2:0] fair_exp[3];
  int         c0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req = '0; bus.req_sprite = '0; bus.req_x = '0; bus.req_y = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    tick();

    // Single draw from requester 0.
    clear_logs();
    lat_fixed = 10;
    set_req(0, 4'd2, 9'd95, 8'd221);
    bus.req = 3'b001;
    c0 = cyc;
    wait_dones(1, 100);
    chk("single_starts", st_cyc.size(), 1);
    if (st_cyc.size() == 1 && dn_cyc.size() == 1) begin
      chk("single_req_to_start", st_cyc[0] - c0, 1);
      chk("single_grant",  st_grant[0], 3'b001);
      chk("single_sprite", st_spr[0], 2);
      chk("single_x",      st_x[0], 95);
      chk("single_y",      st_y[0], 221);
      chk("single_done",   dn_val[0], 3'b001);
      chk("single_done_lat", dn_cyc[0] - st_cyc[0], 11);
    end
    tick();
    bus.req = 3'b000;
    @(negedge clock);
    chk("single_done_width", bus.done, 0);
    chk("single_busy_fall",  busy, 0);

    // Reset pulse mid-transaction with all requesters active, then round robin.
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 5), 9'(10 * i + 1), 8'(20 * i + 3));
    tick();
    bus.req = 3'b111;
    repeat (3) @(posedge clock);
    #3 resetn = 1'b0;
    #1 check_reset_outputs("async_rst");
    tick();
    clear_logs();
    lat_fixed = 4;
    resetn = 1'b1;
    wait_dones(4, 200);
    tick();
    bus.req = 3'b000;
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;
    chk("rr_starts", st_cyc.size(), 4);
    chk("rr_dones",  dn_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < st_cyc.size() && i < dn_cyc.size()) begin
        chk("rr_grant", st_grant[i], rr_exp[i]);
        chk("rr_done",  dn_val[i],   rr_exp[i]);
        chk("rr_draw_lat", dn_cyc[i] - st_cyc[i], 5);
        if (i < 3 && i + 1 < st_cyc.size()) chk("rr_overhead", st_cyc[i+1] - dn_cyc[i], 2);
      end
    end
    repeat (3) tick();

    // Pointer fairness: serve 1, then 3'b101 must go to 2 before 0.
    clear_logs();
    bus.req = 3'b010;
    wait_dones(1, 100);
    tick();
    bus.req = 3'b101;
    wait_dones(2, 100);
    tick();
    bus.req = 3'b000;
    fair_exp[0] = 3'b010; fair_exp[1] = 3'b100; fair_exp[2] = 3'b001;
    chk("fair_starts", st_cyc.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < st_grant.size()) chk("fair_grant", st_grant[i], fair_exp[i]);
    repeat (2) tick();

    // Timeout: drawer never completes.
    clear_logs();
    lat_fixed = 0;
    bus.req = 3'b001;
    wait_dones(1, 100);
    if (st_cyc.size() == 1 && dn_cyc.size() == 1) begin
      chk("to_lat",  dn_cyc[0] - st_cyc[0], TO + 1);
      chk("to_err",  dn_err[0], 1);
      chk("to_done", dn_val[0], 3'b001);
    end
    tick();
    bus.req = 3'b000;
    clear_err = 1'b1;
    @(negedge clock);
    chk("to_err_sticky", timeout_err, 1);
    tick();
    clear_err = 1'b0;
    @(negedge clock);
    chk("to_err_cleared", timeout_err, 0);

    // draw_done on the final WAIT cycle beats the timeout.
    clear_logs();
    lat_fixed = TO;
    tick();
    bus.req = 3'b010;
    wait_dones(1, 100);
    if (st_cyc.size() == 1 && dn_cyc.size() == 1) begin
      chk("edge_lat",  dn_cyc[0] - st_cyc[0], TO + 1);
      chk("edge_err",  dn_err[0], 0);
      chk("edge_done", dn_val[0], 3'b010);
    end
    tick();
    bus.req = 3'b000;

    // Timeout with clear_err held: set wins.
    clear_logs();
    lat_fixed = 0;
    clear_err = 1'b1;
    bus.req = 3'b100;
    wait_dones(1, 100);
    if (dn_err.size() == 1) chk("setwins_err", dn_err[0], 1);
    tick();
    bus.req = 3'b000;
    clear_err = 1'b0;
    repeat (2) tick();

    // Reset during WAIT, then a stale draw_done while idle.
    bus.req = 3'b001;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("mid_busy", busy, 1);
    #2 resetn = 1'b0;
    bus.req = 3'b000;
    tick();
    resetn = 1'b1;
    tick();
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("stale_done", bus.done, 0);
      chk("stale_busy", busy, 0);
      chk("stale_err",  timeout_err, 0);
    end

    // Randomized traffic against the model.
    lat_rand = 1;
    noise_en = 1;
    repeat (2500) begin
      tick();
      if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++)
        set_req(i, 4'($urandom_range(0, 15)), 9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)));
      clear_err = ($urandom_range(0, 29) == 0);
    end
    bus.req = 3'b000;
    clear_err = 1'b0;
    noise_en = 0;
    lat_rand = 0;
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
Name: draw_arbiter

Overview:
- Shares the single sprite drawer between several draw requesters: background restore, character draw, and pillar/bridge animation.
- Sits between the movement/animation FSMs and the sprite drawer. Only one draw is in flight at a time, so the framebuffer never receives interleaved writes.
- Arbitration is round-robin. A transaction is captured atomically from the winning requester. A timeout guards against a drawer that never signals completion.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); index 0 = background, 1 = character, 2 = animation.
- TIMEOUT_CYCLES, 65536, maximum cycles spent in WAIT before the transaction is forcibly retired (at least 2).

Ports:
- clock  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request, level, held until done
- req_sprite  in  4*NUM_REQ  packed sprite IDs, requester i at bits [4i+3:4i]
- req_x  in  9*NUM_REQ  packed X coordinates (0..319)
- req_y  in  8*NUM_REQ  packed Y coordinates (0..239)
- grant  out  NUM_REQ  one-hot owner of the drawer; all zero when idle
- done  out  NUM_REQ  one-cycle completion pulse to the owner
- draw_start  out  1  one-cycle start pulse to the sprite drawer
- draw_sprite  out  4  latched sprite ID
- draw_x  out  9  latched X coordinate
- draw_y  out  8  latched Y coordinate
- draw_done  in  1  drawer completion pulse
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky flag, set when a transaction times out
- clear_err  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (asynchronous, any state): state=IDLE. grant, done, draw_start, draw_sprite, draw_x, draw_y, busy, timeout_err and the timeout counter all go to 0. Pointer ptr=0.
- FSM states: IDLE, START, WAIT, DONE.
- IDLE:
  - If req is nonzero, pick the winner w = first asserted index searching ptr, ptr+1, ... modulo NUM_REQ.
  - At the clock edge: latch sprite/x/y of w into draw_*, set grant=onehot(w), go to START.
  - If req is zero, stay in IDLE; draw_* hold their last values.
- START:
  - draw_start=1 for exactly this cycle.
  - Counter cleared to 0; next state is WAIT.
- WAIT:
  - Counter increments each cycle.
  - draw_done=1 → go to DONE.
  - Otherwise, if counter==TIMEOUT_CYCLES-1 → go to DONE and set timeout_err.
  - If both happen on the same edge, draw_done wins and timeout_err is not set.
- DONE:
  - done[w]=1 for this single cycle; grant stays on w.
  - ptr <= (w+1) mod NUM_REQ.
  - Next state is IDLE; grant clears on entering IDLE.
- Latency: req rises at edge N with the arbiter in IDLE → grant and draw_* valid, and draw_start high, in the cycle after edge N+1. Captured draw_done → done pulse in the next cycle. Back-to-back transactions: the IDLE cycle sits between DONE and the next START, so there is a 3-cycle minimum overhead per draw.
- Input sampling rules:
  - draw_done is sampled only in WAIT; it is ignored in IDLE, START and DONE (stale pulses are dropped).
  - req inputs and operand buses are sampled only in IDLE. Changes, or req deassertion, while granted do not affect the in-flight draw. The draw always completes and the done pulse is still issued.
- A requester that keeps req high after its done re-enters arbitration behind all other pending requesters, because ptr has advanced.
- timeout_err:
  - Remains 1 until clear_err or reset.
  - clear_err and a new timeout on the same edge → timeout_err=1 (set wins).
- Coordinates are passed through unmodified; no range check is performed.
- Width rule: the counter is clog2(TIMEOUT_CYCLES) bits and never wraps, because the terminal comparison exits WAIT first.
- Outputs are registered, except busy, which is decoded from the state register.

Test Plan:
- Reset: pulse resetn low mid-simulation with req=3'b111 → all outputs 0 asynchronously while resetn=0, and the first grant after release is 3'b001.
- Single draw: req[0]=1, sprite=2, x=95, y=221; drawer asserts draw_done 10 cycles after draw_start →
  - draw_start is high for one cycle with draw_sprite=2, draw_x=95, draw_y=221;
  - done=3'b001 for one cycle, the cycle after draw_done;
  - busy falls the following cycle.
- Round-robin: req=3'b111 held throughout, drawer done after 4 cycles → grant sequence 001, 010, 100, 001. Each grant has exactly one draw_start and one done pulse.
- Pointer fairness: after requester 1 is served, present req=3'b101 → requester 2 is granted before requester 0.
- Timeout: TIMEOUT_CYCLES=16, draw_done never asserted → done[w] pulses after exactly 16 WAIT cycles and timeout_err=1; then pulse clear_err → timeout_err=0. With draw_done asserted on the 16th WAIT cycle instead → timeout_err stays 0.
- Reset mid-operation plus stale done: assert resetn low during WAIT, release, then pulse draw_done while in IDLE with req=0 → no done pulse, state remains IDLE, timeout_err=0.
